stall_controller: RTL and testbench

STALL_CONTROLLER -- requirements
Module: stall_controller

---
 rtl/stall_pkg.sv | 73 +++++++
 rtl/stall_cycle_counter.sv | 37 +++
 rtl/stall_controller.sv | 168 ++++++++++++++++
 tb/tb_stall_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stall_pkg.sv
// ---------------------------------------------------------------------------
// stall_pkg
//   Shared definitions for the pipeline stall controller: the FSM state
//   encoding, the default memory timeout, the bundle of pipeline control
//   strobes and small helpers that build that bundle.
// ---------------------------------------------------------------------------
package stall_pkg;

  // Controller states; encoding is fixed so external tools can decode it.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } stall_state_e;

  // Default number of MEM_WAIT cycles tolerated before a timeout.
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  // Wait counter is a fixed 8 bits wide.
  localparam int unsigned WAIT_CNT_W = 8;
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = 8'hFF;

  // One bit per pipeline control strobe.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic bubble_id_ex;
    logic freeze_mem;
  } stall_ctrl_t;

  // Whole pipeline held while memory is outstanding (or after a timeout).
  localparam stall_ctrl_t CTRL_FREEZE_ALL = '{
    freeze_pc:    1'b1,
    freeze_if_id: 1'b1,
    flush_if_id:  1'b0,
    bubble_id_ex: 1'b0,
    freeze_mem:   1'b1
  };

  // Front-end control when memory is not holding the pipe. A taken branch
  // squashes the wrong-path fetch, which also removes the hazarding
  // instruction, so it wins over a RAW hazard.
  function automatic stall_ctrl_t pipe_ctrl(input logic branch,
                                            input logic hazard);
    stall_ctrl_t c;
    c = '0;
    if (branch) begin
      c.flush_if_id  = 1'b1;
      c.bubble_id_ex = 1'b1;
    end else if (hazard) begin
      c.freeze_pc    = 1'b1;
      c.freeze_if_id = 1'b1;
      c.bubble_id_ex = 1'b1;
    end else begin
      c = '0;
    end
    return c;
  endfunction

  // Saturating increment so the wait counter can never wrap to zero.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc8(
      input logic [WAIT_CNT_W-1:0] v);
    logic [WAIT_CNT_W-1:0] r;
    if (v == WAIT_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stall_cycle_counter.sv
// ---------------------------------------------------------------------------
// stall_cycle_counter
//   Saturating event counter: counts clock cycles with en=1 and sticks at
//   all-ones.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-low reset (clears the count)
//   en    - count this cycle
//   count - current count, W bits
// ---------------------------------------------------------------------------
module stall_cycle_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_r;

  // Count enabled cycles, holding at all-ones once reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= '0;
    end else if (en && (count_r != '1)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/stall_controller.sv
// ---------------------------------------------------------------------------
// stall_controller
//   Central pipeline stall/flush controller. Combines RAW-hazard stalls,
//   taken-branch flushes and multi-cycle data-memory waits, and halts the
//   pipeline permanently (until reset) if memory never answers.
//
//   Optional feature: define STALL_STATS_EN to add the stall_cycles port,
//   a saturating count of cycles in which the PC was frozen.
//
// Ports:
//   clk             - sole clock, rising edge
//   rst             - synchronous, active-low reset
//   hazard_detected - RAW hazard flag from the hazard unit
//   branch_taken    - taken branch/jump resolved in EX
//   mem_req         - MEM stage holds a load/store
//   mem_ready       - data memory completes the access this cycle
//   freeze_pc       - hold PC
//   freeze_if_id    - hold IF/ID
//   flush_if_id     - load NOP into IF/ID
//   bubble_id_ex    - load NOP into ID/EX
//   freeze_mem      - hold ID/EX, EX/MEM and MEM/WB
//   mem_timeout     - sticky memory timeout flag
//   stall_cycles    - (STALL_STATS_EN only) frozen-PC cycle count
// ---------------------------------------------------------------------------
module stall_controller
  import stall_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_detected,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_pc,
  output logic              freeze_if_id,
  output logic              flush_if_id,
  output logic              bubble_id_ex,
  output logic              freeze_mem,
  output logic              mem_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles
`endif
);

  // Reject unusable parameter values at elaboration.
  if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255) || (STAT_W < 1)) begin : g_param_check
    $error("stall_controller: MEM_TIMEOUT must be 1..255 and STAT_W >= 1");
  end

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  stall_state_e           state_r;
  stall_state_e           next_state_s;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r;
  logic [WAIT_CNT_W-1:0]  next_wait_cnt_s;
  logic                   mem_timeout_r;
  logic                   next_mem_timeout_s;
  stall_ctrl_t            ctrl_s;

  // State register: FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      wait_cnt_r    <= next_wait_cnt_s;
      mem_timeout_r <= next_mem_timeout_s;
    end
  end

  // Next-state logic. wait_cnt is 1 in the first MEM_WAIT cycle, because
  // the RUN cycle that issued the unanswered request already counted as a
  // wait cycle.
  always_comb begin
    next_state_s       = state_r;
    next_wait_cnt_s    = wait_cnt_r;
    next_mem_timeout_s = mem_timeout_r;
    case (state_r)
      RUN: begin
        if (mem_req && !mem_ready) begin
          next_state_s    = MEM_WAIT;
          next_wait_cnt_s = 8'd1;
        end else begin
          next_state_s    = RUN;
          next_wait_cnt_s = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          next_wait_cnt_s = sat_inc8(wait_cnt_r);
          if (wait_cnt_r == TIMEOUT_CNT) begin
            next_state_s       = HALTED;
            next_mem_timeout_s = 1'b1;
          end else begin
            next_state_s = MEM_WAIT;
          end
        end else begin
          next_state_s    = RUN;
          next_wait_cnt_s = 8'd0;
        end
      end
      HALTED: begin
        // Only reset leaves HALTED.
        next_state_s = HALTED;
      end
      default: begin
        // Unreachable encoding: park the pipe frozen rather than guess.
        next_state_s = HALTED;
      end
    endcase
  end

  // Output logic: combinational from state and inputs, forced quiet in reset.
  always_comb begin
    ctrl_s = '0;
    if (!rst) begin
      ctrl_s = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_req && !mem_ready) begin
            ctrl_s = CTRL_FREEZE_ALL;
          end else begin
            ctrl_s = pipe_ctrl(branch_taken, hazard_detected);
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            ctrl_s = CTRL_FREEZE_ALL;
          end else begin
            ctrl_s = pipe_ctrl(branch_taken, hazard_detected);
          end
        end
        HALTED: begin
          ctrl_s = CTRL_FREEZE_ALL;
        end
        default: begin
          ctrl_s = CTRL_FREEZE_ALL;
        end
      endcase
    end
  end

  assign freeze_pc    = ctrl_s.freeze_pc;
  assign freeze_if_id = ctrl_s.freeze_if_id;
  assign flush_if_id  = ctrl_s.flush_if_id;
  assign bubble_id_ex = ctrl_s.bubble_id_ex;
  assign freeze_mem   = ctrl_s.freeze_mem;
  assign mem_timeout  = mem_timeout_r;

`ifdef STALL_STATS_EN
  stall_cycle_counter #(
    .W (STAT_W)
  ) u_stall_cycle_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_s.freeze_pc),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_stall_controller
//   Directed scenarios followed by random traffic, each cycle compared with
//   a behavioural model of the stall rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_stall_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned STAT_W      = 4;
  localparam int          STAT_MAX    = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic hazard_detected;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;
  logic freeze_pc;
  logic freeze_if_id;
  logic flush_if_id;
  logic bubble_id_ex;
  logic freeze_mem;
  logic mem_timeout;
`ifdef STALL_STATS_EN
  logic [STAT_W-1:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  string phase = "init";

  // Reference model: cycles already spent on the current memory access
  // (0 = no access outstanding), halted/timeout flags, frozen-PC count.
  int waited = 0;
  bit halted = 1'b0;
  bit tmo    = 1'b0;
  int stalls = 0;

  always #5 clk = ~clk;

  stall_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .STAT_W      (STAT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .freeze_pc       (freeze_pc),
    .freeze_if_id    (freeze_if_id),
    .flush_if_id     (flush_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .freeze_mem      (freeze_mem),
    .mem_timeout     (mem_timeout)
`ifdef STALL_STATS_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs against
  // the model, then advance the model to what the next rising edge does.
  task automatic step(input logic r, input logic h, input logic b,
                      input logic q, input logic y);
    logic e_fpc, e_fif, e_fl, e_bub, e_fm;
    bit   mem_stall;
    @(negedge clk);
    rst = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y;
    #1;
    e_fpc = 1'b0; e_fif = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_fm = 1'b0;
    mem_stall = 1'b0;
    if (r) begin
      if (halted) begin
        e_fpc = 1'b1; e_fif = 1'b1; e_fm = 1'b1;
      end else begin
        mem_stall = (waited == 0) ? (q && !y) : !y;
        if (mem_stall) begin
          e_fpc = 1'b1; e_fif = 1'b1; e_fm = 1'b1;
        end else if (b) begin
          e_fl = 1'b1; e_bub = 1'b1;
        end else if (h) begin
          e_fpc = 1'b1; e_fif = 1'b1; e_bub = 1'b1;
        end
      end
    end
    chk("freeze_pc",    32'(freeze_pc),    32'(e_fpc));
    chk("freeze_if_id", 32'(freeze_if_id), 32'(e_fif));
    chk("flush_if_id",  32'(flush_if_id),  32'(e_fl));
    chk("bubble_id_ex", 32'(bubble_id_ex), 32'(e_bub));
    chk("freeze_mem",   32'(freeze_mem),   32'(e_fm));
    chk("mem_timeout",  32'(mem_timeout),  32'(tmo));
`ifdef STALL_STATS_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(stalls));
`endif
    if (!r) begin
      waited = 0; halted = 1'b0; tmo = 1'b0; stalls = 0;
    end else begin
      if (e_fpc && stalls < STAT_MAX) stalls++;
      if (!halted) begin
        if (mem_stall) begin
          if (waited >= MEM_TIMEOUT) begin
            halted = 1'b1; tmo = 1'b1;
          end else begin
            waited++;
          end
        end else begin
          waited = 0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: outputs quiet even with every input asserted.
    phase = "reset";
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_fpc_const", 32'(freeze_pc), 32'd0);

    // RAW hazard for two cycles.
    phase = "hazard";
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("haz1_bubble", 32'(bubble_id_ex), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("haz2_fpc", 32'(freeze_pc), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("haz_after_fpc", 32'(freeze_pc), 32'd0);
`ifdef STALL_STATS_EN
    chk("haz_stat2", 32'(stall_cycles), 32'd2);
`endif

    // Branch wins over a simultaneous hazard.
    phase = "branch";
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("br_flush", 32'(flush_if_id), 32'd1);
    chk("br_fpc",   32'(freeze_pc),   32'd0);

    // Memory answers after three wait cycles.
    phase = "memwait";
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mw1_fm", 32'(freeze_mem), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mw3_fm", 32'(freeze_mem), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mw4_fm", 32'(freeze_mem), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mw_back_run", 32'(freeze_mem), 32'd0);

    // Zero-latency access: no freeze at all.
    phase = "memfast";
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fast_fm", 32'(freeze_mem), 32'd0);

    // Timeout: memory never answers, then inputs toggle while halted.
    phase = "timeout";
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i & 1), 1'(i >> 1), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'(i & 1), 1'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b1);
    chk("tmo_flag",  32'(mem_timeout), 32'd1);
    chk("tmo_fpc",   32'(freeze_pc),   32'd1);
    chk("tmo_flush", 32'(flush_if_id), 32'd0);

    // Reset out of HALTED, then out of MEM_WAIT.
    phase = "rst_halted";
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rh_tmo", 32'(mem_timeout), 32'd0);
    phase = "rst_memwait";
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rm_fm", 32'(freeze_mem), 32'd0);
`ifdef STALL_STATS_EN
    chk("rm_stat0", 32'(stall_cycles), 32'd0);
`endif

    // Long hazard: statistics saturate.
    phase = "saturate";
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STALL_STATS_EN
    chk("sat_stat", 32'(stall_cycles), 32'(STAT_MAX));
`endif

    // Random traffic against the model.
    phase = "random";
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
